// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the three-requester RAM bus arbiter: owner
// encodings, round-robin pointer encoding, default starvation threshold and
// the width of the per-DMA wait counters.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Current bus owner; the numeric values are visible on the owner port.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA0 = 2'd2,
        OWN_DMA1 = 2'd3
    } owner_t;

    // Round-robin pointer: names the DMA that gets the next tie.
    typedef enum logic {
        RR_DMA0 = 1'b0,
        RR_DMA1 = 1'b1
    } rr_t;

    // Cycles a DMA may wait before it is treated as starved (legal 1..15).
    localparam int unsigned DEFAULT_MAX_WAIT = 8;

    // Four bits hold any legal MAX_WAIT value.
    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/arb_wait_cnt.sv
// ---------------------------------------------------------------------------
// arb_wait_cnt
// Per-DMA wait counter. Counts cycles during which the requester asks for the
// bus without holding it, saturates at MAX_WAIT and clears as soon as the
// request is withdrawn or the grant is held.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      in   requester's bus request
//   gnt      in   requester's registered grant
//   starved  out  registered flag: counter sits at MAX_WAIT
// ---------------------------------------------------------------------------
module arb_wait_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] ONE_CNT = WAIT_W'(1);

    logic [WAIT_W-1:0] cnt_r;
    logic [WAIT_W-1:0] cnt_nxt_s;
    logic              starved_r;

    // Next counter value: clear, saturate or increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!req || gnt) begin
            cnt_nxt_s = '0;
        end else if (cnt_r != MAX_CNT) begin
            cnt_nxt_s = cnt_r + ONE_CNT;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and starvation flag registers; the flag tracks the counter so
    // it is valid in the same cycle the counter reaches MAX_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= '0;
            starved_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            starved_r <= (cnt_nxt_s == MAX_CNT);
        end
    end

    assign starved = starved_r;

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Arbitrates one RAM port between a CPU and two DMA engines. Ownership is
// non-preemptive; on release the bus is handed over at the same edge to the
// best remaining requester (starved DMA > cpu > non-starved DMA, DMA ties by
// round-robin). The owner's address, write data and write enable are muxed
// onto the RAM port; read data is not routed here.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   cpu_req/dma0_req/dma1_req      bus requests (held for whole ownership)
//   cpu_gnt/dma0_gnt/dma1_gnt      registered one-hot grants
//   *_addr, *_w, *_w_en            requester address / write data / enable
//   ram_rw_addr, ram_w, ram_w_en   owner's signals, zero when idle
//   owner                          0 idle, 1 cpu, 2 dma0, 3 dma1
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       dma0_req,
    input  logic       dma1_req,
    output logic       cpu_gnt,
    output logic       dma0_gnt,
    output logic       dma1_gnt,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] dma0_addr,
    input  logic [7:0] dma1_addr,
    input  logic [7:0] cpu_w,
    input  logic [7:0] dma0_w,
    input  logic [7:0] dma1_w,
    input  logic       cpu_w_en,
    input  logic       dma0_w_en,
    input  logic       dma1_w_en,
    output logic [7:0] ram_rw_addr,
    output logic [7:0] ram_w,
    output logic       ram_w_en,
    output logic [1:0] owner
);

    owner_t owner_r;
    owner_t owner_nxt_s;
    owner_t winner_s;
    rr_t    rr_r;
    rr_t    rr_nxt_s;
    logic   cpu_gnt_r;
    logic   dma0_gnt_r;
    logic   dma1_gnt_r;
    logic   hold_s;
    logic   cpu_cand_s;
    logic   dma0_cand_s;
    logic   dma1_cand_s;
    logic   dma0_st_s;
    logic   dma1_st_s;
    logic   dma0_starved_s;
    logic   dma1_starved_s;

    arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_dma0 (
        .clk     (clk),
        .rst     (rst),
        .req     (dma0_req),
        .gnt     (dma0_gnt_r),
        .starved (dma0_starved_s)
    );

    arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_dma1 (
        .clk     (clk),
        .rst     (rst),
        .req     (dma1_req),
        .gnt     (dma1_gnt_r),
        .starved (dma1_starved_s)
    );

    // Candidate set and winner among requesters other than the current owner.
    // The starved flag is masked with req because it lags a dropped request
    // by one cycle.
    always_comb begin
        cpu_cand_s  = cpu_req  && (owner_r != OWN_CPU);
        dma0_cand_s = dma0_req && (owner_r != OWN_DMA0);
        dma1_cand_s = dma1_req && (owner_r != OWN_DMA1);
        dma0_st_s   = dma0_cand_s && dma0_starved_s;
        dma1_st_s   = dma1_cand_s && dma1_starved_s;
        winner_s    = OWN_IDLE;
        if (dma0_st_s && dma1_st_s) begin
            winner_s = (rr_r == RR_DMA0) ? OWN_DMA0 : OWN_DMA1;
        end else if (dma0_st_s) begin
            winner_s = OWN_DMA0;
        end else if (dma1_st_s) begin
            winner_s = OWN_DMA1;
        end else if (cpu_cand_s) begin
            winner_s = OWN_CPU;
        end else if (dma0_cand_s && dma1_cand_s) begin
            winner_s = (rr_r == RR_DMA0) ? OWN_DMA0 : OWN_DMA1;
        end else if (dma0_cand_s) begin
            winner_s = OWN_DMA0;
        end else if (dma1_cand_s) begin
            winner_s = OWN_DMA1;
        end else begin
            winner_s = OWN_IDLE;
        end
    end

    // Owner keeps the bus while its request stays high; otherwise hand over.
    always_comb begin
        hold_s = 1'b0;
        case (owner_r)
            OWN_CPU:  hold_s = cpu_req;
            OWN_DMA0: hold_s = dma0_req;
            OWN_DMA1: hold_s = dma1_req;
            default:  hold_s = 1'b0;
        endcase
        owner_nxt_s = hold_s ? owner_r : winner_s;
    end

    // Round-robin pointer moves to the other DMA whenever a DMA owns the bus.
    always_comb begin
        rr_nxt_s = rr_r;
        case (owner_nxt_s)
            OWN_DMA0: rr_nxt_s = RR_DMA1;
            OWN_DMA1: rr_nxt_s = RR_DMA0;
            default:  rr_nxt_s = rr_r;
        endcase
    end

    // Owner, grant and round-robin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r    <= OWN_IDLE;
            rr_r       <= RR_DMA0;
            cpu_gnt_r  <= 1'b0;
            dma0_gnt_r <= 1'b0;
            dma1_gnt_r <= 1'b0;
        end else begin
            owner_r    <= owner_nxt_s;
            rr_r       <= rr_nxt_s;
            cpu_gnt_r  <= (owner_nxt_s == OWN_CPU);
            dma0_gnt_r <= (owner_nxt_s == OWN_DMA0);
            dma1_gnt_r <= (owner_nxt_s == OWN_DMA1);
        end
    end

    // RAM port mux driven by the registered owner, so a non-owner never
    // reaches the RAM and reset zeroes the port immediately.
    always_comb begin
        ram_rw_addr = 8'h00;
        ram_w       = 8'h00;
        ram_w_en    = 1'b0;
        case (owner_r)
            OWN_CPU: begin
                ram_rw_addr = cpu_addr;
                ram_w       = cpu_w;
                ram_w_en    = cpu_w_en;
            end
            OWN_DMA0: begin
                ram_rw_addr = dma0_addr;
                ram_w       = dma0_w;
                ram_w_en    = dma0_w_en;
            end
            OWN_DMA1: begin
                ram_rw_addr = dma1_addr;
                ram_w       = dma1_w;
                ram_w_en    = dma1_w_en;
            end
            default: begin
                ram_rw_addr = 8'h00;
                ram_w       = 8'h00;
                ram_w_en    = 1'b0;
            end
        endcase
    end

    assign cpu_gnt  = cpu_gnt_r;
    assign dma0_gnt = dma0_gnt_r;
    assign dma1_gnt = dma1_gnt_r;
    assign owner    = owner_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Scoreboard bench: each step pushes the expected owner and RAM-port values
// derived from the inputs just driven, then pops and compares them one edge
// later.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, dma0_req, dma1_req;
    logic       cpu_gnt, dma0_gnt, dma1_gnt;
    logic [7:0] cpu_addr, dma0_addr, dma1_addr;
    logic [7:0] cpu_w, dma0_w, dma1_w;
    logic       cpu_w_en, dma0_w_en, dma1_w_en;
    logic [7:0] ram_rw_addr, ram_w;
    logic       ram_w_en;
    logic [1:0] owner;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] own;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       wen;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_WAIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .dma0_req    (dma0_req),
        .dma1_req    (dma1_req),
        .cpu_gnt     (cpu_gnt),
        .dma0_gnt    (dma0_gnt),
        .dma1_gnt    (dma1_gnt),
        .cpu_addr    (cpu_addr),
        .dma0_addr   (dma0_addr),
        .dma1_addr   (dma1_addr),
        .cpu_w       (cpu_w),
        .dma0_w      (dma0_w),
        .dma1_w      (dma1_w),
        .cpu_w_en    (cpu_w_en),
        .dma0_w_en   (dma0_w_en),
        .dma1_w_en   (dma1_w_en),
        .ram_rw_addr (ram_rw_addr),
        .ram_w       (ram_w),
        .ram_w_en    (ram_w_en),
        .owner       (owner)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected RAM port for an owner, taken from the inputs currently driven.
    task automatic push_exp(input string tag, input logic [1:0] own);
        exp_t e;
        e.tag = tag;
        e.own = own;
        case (own)
            2'd1:    begin e.addr = cpu_addr;  e.wd = cpu_w;  e.wen = cpu_w_en;  end
            2'd2:    begin e.addr = dma0_addr; e.wd = dma0_w; e.wen = dma0_w_en; end
            2'd3:    begin e.addr = dma1_addr; e.wd = dma1_w; e.wen = dma1_w_en; end
            default: begin e.addr = 8'h00;     e.wd = 8'h00;  e.wen = 1'b0;      end
        endcase
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        logic [2:0] gexp;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e    = sb_q.pop_front();
            gexp = {e.own == 2'd1, e.own == 2'd2, e.own == 2'd3};
            check_val({e.tag, "_owner"}, 32'(owner), 32'(e.own));
            check_val({e.tag, "_gnt"}, 32'({cpu_gnt, dma0_gnt, dma1_gnt}), 32'(gexp));
            check_val({e.tag, "_addr"}, 32'(ram_rw_addr), 32'(e.addr));
            check_val({e.tag, "_wdata"}, 32'(ram_w), 32'(e.wd));
            check_val({e.tag, "_wen"}, 32'(ram_w_en), 32'(e.wen));
        end
    endtask

    // Inputs are already driven; expect `own` after the next rising edge.
    task automatic step(input string tag, input logic [1:0] own);
        push_exp(tag, own);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_owner"}, 32'(owner), 32'd0);
        check_val({tag, "_gnt"}, 32'({cpu_gnt, dma0_gnt, dma1_gnt}), 32'd0);
        check_val({tag, "_addr"}, 32'(ram_rw_addr), 32'd0);
        check_val({tag, "_wen"}, 32'(ram_w_en), 32'd0);
    endtask

    task automatic set_dma_req(input logic [1:0] own, input logic val);
        if (own == 2'd2) dma0_req = val;
        else             dma1_req = val;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] cur;
        logic [1:0] nxt;
        rst = 1'b0;
        cpu_req = 1'b1; dma0_req = 1'b0; dma1_req = 1'b0;
        cpu_addr = 8'h3C; dma0_addr = 8'h80; dma1_addr = 8'h55;
        cpu_w = 8'h11; dma0_w = 8'h22; dma1_w = 8'h33;
        cpu_w_en = 1'b1; dma0_w_en = 1'b0; dma1_w_en = 1'b0;

        // Reset holds everything idle even with a request and a clock edge.
        #2;
        check_idle("rst_state");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        cpu_req = 1'b0;
        rst = 1'b1;
        step("idle", 2'd0);

        // CPU grant, address routing, non-owner write enable blocked.
        cpu_req = 1'b1;
        step("cpu_grant", 2'd1);
        cpu_w_en = 1'b0; dma0_w_en = 1'b1;
        step("cpu_nonowner_wen", 2'd1);
        cpu_req = 1'b0;
        step("cpu_release", 2'd0);

        // All three from idle: cpu wins, then zero-gap handovers.
        cpu_req = 1'b1; dma0_req = 1'b1; dma1_req = 1'b1; cpu_w_en = 1'b1;
        step("all3_cpu", 2'd1);
        cpu_req = 1'b0;
        step("all3_dma0", 2'd2);
        step("all3_dma0_hold", 2'd2);
        dma0_req = 1'b0;
        step("all3_dma1", 2'd3);
        dma1_req = 1'b0;
        step("all3_idle", 2'd0);

        // Long CPU hold with dma1 waiting; no preemption, then dma1 wins.
        cpu_req = 1'b1; dma1_req = 1'b1; dma1_w_en = 1'b1;
        for (int i = 0; i < 20; i++) step("cpu_long", 2'd1);
        cpu_req = 1'b0;
        step("starve_dma1", 2'd3);
        cpu_req = 1'b1;
        step("dma1_keep", 2'd3);
        dma1_req = 1'b0;
        step("cpu_after_dma1", 2'd1);
        cpu_req = 1'b0;
        step("idle2", 2'd0);

        // Starved dma1 beats a waiting cpu.
        dma0_req = 1'b1;
        step("dma0_own", 2'd2);
        cpu_req = 1'b1; dma1_req = 1'b1;
        for (int i = 0; i < 10; i++) step("dma0_long", 2'd2);
        dma0_req = 1'b0;
        step("starved_over_cpu", 2'd3);
        dma1_req = 1'b0;
        step("cpu_after_starved", 2'd1);
        cpu_req = 1'b0;
        step("idle3", 2'd0);

        // Non-starved dma1 loses to cpu.
        dma0_req = 1'b1;
        step("dma0_own2", 2'd2);
        cpu_req = 1'b1; dma1_req = 1'b1;
        for (int i = 0; i < 3; i++) step("dma0_short", 2'd2);
        dma0_req = 1'b0;
        step("cpu_over_dma1", 2'd1);
        cpu_req = 1'b0;
        step("dma1_after_cpu", 2'd3);
        dma1_req = 1'b0;
        step("idle4", 2'd0);

        // DMAs alternating back-to-back with cpu idle: dma0, dma1, dma0, dma1.
        dma0_req = 1'b1; dma1_req = 1'b1;
        step("alt_first", 2'd2);
        cur = 2'd2;
        for (int k = 0; k < 3; k++) begin
            step("alt_hold", cur);
            nxt = (cur == 2'd2) ? 2'd3 : 2'd2;
            set_dma_req(cur, 1'b0);
            step("alt_handover", nxt);
            set_dma_req(cur, 1'b1);
            cur = nxt;
        end
        dma0_req = 1'b0; dma1_req = 1'b0;
        step("alt_idle", 2'd0);

        // Asynchronous reset mid-ownership, then resume one edge after release.
        dma0_req = 1'b1; dma0_addr = 8'h80; dma0_w_en = 1'b1;
        step("dma0_pre_rst", 2'd2);
        #3;
        rst = 1'b0;
        #1;
        check_idle("rst_async");
        @(posedge clk);
        #1;
        check_idle("rst_low_edge");
        rst = 1'b1;
        step("rst_resume", 2'd2);
        dma0_req = 1'b0;
        step("final_idle", 2'd0);

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
